// File: rtl/prime_check_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : prime_check_responder_if
// Purpose  : start/value/result/done/busy primality handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface prime_check_responder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] value;
  logic             result;
  logic             done;
  logic             busy;

  modport master (
    output start,
    output value,
    input  result,
    input  done,
    input  busy
  );

  modport slave (
    input  start,
    input  value,
    output result,
    output done,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/prime_check_responder.sv
`default_nettype none
// ============================================================================
// Module   : prime_check_responder
// Purpose  : Primality responder using trial division over a restoring divider.
//            Optional macro PRIME_ODD_ONLY_EN: try only 2 and odd divisors.
// Revision : 1.0 - initial release
// ============================================================================
module prime_check_responder #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  prime_check_responder_if.slave pc_if
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_DIV   = 3'd2,
    S_TEST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q;
  logic [WIDTH-1:0]   n_q;
  logic [WIDTH-1:0]   d_q;
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   rem_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               result_q;
  logic               done_q;
  logic               busy_q;

  logic [2*WIDTH-1:0] d_sq;
  logic [2*WIDTH-1:0] n_ext;
  logic [WIDTH-1:0]   d_next;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     trial_diff;
  logic               trial_ge;

  // Full-width square so the d*d > n test can never wrap.
  assign d_sq  = {{WIDTH{1'b0}}, d_q} * {{WIDTH{1'b0}}, d_q};
  assign n_ext = {{WIDTH{1'b0}}, n_q};

  // Partial remainder is always below d, so one extra bit holds the shifted trial.
  assign trial      = {rem_q, dvd_q[WIDTH-1]};
  assign trial_ge   = (trial >= {1'b0, d_q});
  assign trial_diff = trial - {1'b0, d_q};

`ifdef PRIME_ODD_ONLY_EN
  assign d_next = (d_q == WIDTH'(2)) ? WIDTH'(3) : d_q + WIDTH'(2);
`else
  assign d_next = d_q + WIDTH'(1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      d_q      <= '0;
      dvd_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (pc_if.start) begin
            n_q      <= pc_if.value;
            d_q      <= WIDTH'(2);
            result_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (!pc_if.start) begin
            result_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else if (n_q < WIDTH'(2)) begin
            result_q <= 1'b0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_DONE;
          end else if (d_sq > n_ext) begin
            result_q <= 1'b1;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_DONE;
          end else begin
            dvd_q   <= n_q;
            rem_q   <= '0;
            cnt_q   <= CNT_W'(WIDTH);
            state_q <= S_DIV;
          end
        end

        S_DIV: begin
          if (!pc_if.start) begin
            result_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            rem_q <= trial_ge ? trial_diff[WIDTH-1:0] : trial[WIDTH-1:0];
            dvd_q <= {dvd_q[WIDTH-2:0], trial_ge};
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= S_TEST;
            end
          end
        end

        S_TEST: begin
          if (!pc_if.start) begin
            result_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else if (rem_q == '0) begin
            result_q <= 1'b0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_DONE;
          end else begin
            d_q     <= d_next;
            state_q <= S_CHECK;
          end
        end

        S_DONE: begin
          if (!pc_if.start) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: begin
          result_q <= 1'b0;
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign pc_if.result = result_q;
  assign pc_if.done   = done_q;
  assign pc_if.busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_prime_check_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_prime_check_responder
// Purpose  : Vector table plus abort/hold sequences for prime_check_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prime_check_responder;

  localparam int WIDTH = 32;
`ifdef PRIME_ODD_ONLY_EN
  localparam bit ODD = 1'b1;
`else
  localparam bit ODD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prime_check_responder_if #(.WIDTH(WIDTH)) bus ();

  prime_check_responder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .pc_if (bus)
  );

  typedef struct {
    logic [WIDTH-1:0] value;
    logic             exp_result;
    int               exp_lat;
    logic [WIDTH-1:0] alt_value;
    int               alt_at;
  } vec_t;

  typedef struct {
    logic result;
    int   lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[13];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int lat(input int base_lat, input int odd_lat);
    return ODD ? odd_lat : base_lat;
  endfunction

  // Drives one request, counts edges after the sampling edge until done rises.
  task automatic run_vec(input vec_t v);
    exp_t e;
    int   n;
    bit   seen;
    e.result = v.exp_result;
    e.lat    = v.exp_lat;
    sb.push_back(e);
    @(negedge clk);
    bus.value = v.value;
    bus.start = 1'b1;
    @(posedge clk); #1;
    check("busy_after_start", {63'd0, bus.busy}, 64'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (v.alt_at == n) bus.value = v.alt_value;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check("done_seen", {63'd0, seen}, 64'd1);
    e = sb.pop_front();
    check($sformatf("result_%0d", v.value), {63'd0, bus.result}, {63'd0, e.result});
    check($sformatf("latency_%0d", v.value), 64'(n), 64'(e.lat));
    check("busy_in_done", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("done_clear", {63'd0, bus.done}, 64'd0);
  endtask

  initial begin
    bit any_done;
    int n;

    vecs[0]  = '{32'd2,          1'b1, lat(1, 1),       32'd0,    0};
    vecs[1]  = '{32'd0,          1'b0, lat(1, 1),       32'd0,    0};
    vecs[2]  = '{32'd1,          1'b0, lat(1, 1),       32'd0,    0};
    vecs[3]  = '{32'd3,          1'b1, lat(1, 1),       32'd0,    0};
    vecs[4]  = '{32'd4,          1'b0, lat(34, 34),     32'd0,    0};
    vecs[5]  = '{32'd7,          1'b1, lat(35, 35),     32'd0,    0};
    vecs[6]  = '{32'd9,          1'b0, lat(68, 68),     32'd0,    0};
    vecs[7]  = '{32'd25,         1'b0, lat(136, 102),   32'd0,    0};
    vecs[8]  = '{32'd49,         1'b0, lat(204, 136),   32'd0,    0};
    vecs[9]  = '{32'd97,         1'b1, lat(273, 171),   32'd0,    0};
    // 3851658759 = 3 * 1283886253; value is swapped mid-divide.
    vecs[10] = '{32'd3851658759, 1'b0, lat(68, 68),     32'd6857, 20};
    vecs[11] = '{32'd6857,       1'b1, lat(2755, 1395), 32'd0,    0};
    vecs[12] = '{32'd4294967295, 1'b0, lat(68, 68),     32'd0,    0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.value = '0;
    #12;
    check("reset_done",   {63'd0, bus.done},   64'd0);
    check("reset_result", {63'd0, bus.result}, 64'd0);
    check("reset_busy",   {63'd0, bus.busy},   64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i]);
    end

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    bus.value = 32'd25;
    bus.start = 1'b1;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_abort_done", {63'd0, bus.done}, 64'd0);
    check("rst_abort_busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("rst_idle_busy", {63'd0, bus.busy}, 64'd0);
    run_vec('{32'd13, 1'b1, lat(69, 69), 32'd0, 0});

    // Start withdrawn during a divide: no verdict may appear.
    @(negedge clk);
    bus.value = 32'd9;
    bus.start = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    any_done  = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) any_done = 1'b1;
    end
    check("drop_no_done", {63'd0, any_done}, 64'd0);
    check("drop_busy",    {63'd0, bus.busy}, 64'd0);

    // Start held after the verdict keeps DONE until released.
    @(negedge clk);
    bus.value = 32'd2;
    bus.start = 1'b1;
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_latency", 64'(n), 64'd2);
    bus.value = 32'd4;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("hold_done",   {63'd0, bus.done},   64'd1);
      check("hold_result", {63'd0, bus.result}, 64'd1);
    end
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("hold_release", {63'd0, bus.done}, 64'd0);
    run_vec('{32'd7, 1'b1, lat(35, 35), 32'd0, 0});

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
